// File: rtl/rand_io_harness_if.sv
// Bus bundle for rand_io_harness: generator controls, write/read data,
// observation port and signature outputs.
interface rand_io_harness_if #(
  parameter int NUM_CH = 2,
  parameter int LANES  = 32,
  parameter int DWIDTH = 8
);
  localparam int W         = LANES * DWIDTH;
  localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_BITS = $clog2(W / 8);
  localparam int SEL_W     = CH_BITS + BYTE_BITS;

  logic [1:0]          gen_mode;
  logic                step;
  logic [31:0]         seed_in;
  logic [NUM_CH*W-1:0] wdata_flat;
  logic [NUM_CH*W-1:0] rdata_flat;
  logic [SEL_W-1:0]    o_sel;
  logic [7:0]          o_data;
  logic                capture_en;
  logic                sig_clear;
  logic [31:0]         o_sig;
  logic [15:0]         cap_count;

  modport master (
    output gen_mode, step, seed_in, rdata_flat, o_sel, capture_en, sig_clear,
    input  wdata_flat, o_data, o_sig, cap_count
  );

  modport slave (
    input  gen_mode, step, seed_in, rdata_flat, o_sel, capture_en, sig_clear,
    output wdata_flat, o_data, o_sig, cap_count
  );
endinterface

// File: rtl/rand_io_harness.sv
// Stimulus/observation harness: per-channel LFSR write-data generators,
// MISR compression of read data and a registered byte observation port.
module rand_io_harness #(
  parameter int          NUM_CH = 2,
  parameter int          LANES  = 32,
  parameter int          DWIDTH = 8,
  parameter logic [31:0] SEED   = 32'h1
) (
  input logic              clk,
  input logic              reset,
  rand_io_harness_if.slave bus
);
  localparam int W         = LANES * DWIDTH;
  localparam int NWORDS    = NUM_CH * W / 32;
  localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_BITS = $clog2(W / 8);
  localparam int SEL_W     = CH_BITS + BYTE_BITS;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FREE = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } gen_mode_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Zero is the LFSR lock-up state, so any seed that would land there becomes 1.
  function automatic logic [31:0] nz(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] w, input logic [31:0] v);
    logic [W+31:0] t;
    t = {w, v};
    return t[W-1:0];
  endfunction

  logic [31:0]      lfsr_q  [NUM_CH];
  logic [31:0]      lfsr_d  [NUM_CH];
  logic [W-1:0]     wdata_q [NUM_CH];
  logic [W-1:0]     wdata_d [NUM_CH];
  logic [7:0]       o_data_q, o_data_d;
  logic [31:0]      sig_q, sig_d;
  logic [15:0]      cap_q, cap_d;
  logic [31:0]      fold;
  logic [CH_BITS-1:0]   ch_sel;
  logic [BYTE_BITS-1:0] byte_sel;
  gen_mode_e        mode;
  logic             advance;

  assign mode     = gen_mode_e'(bus.gen_mode);
  assign advance  = (mode == MODE_FREE) || ((mode == MODE_STEP) && bus.step);
  assign ch_sel   = bus.o_sel[CH_BITS-1:0];
  assign byte_sel = bus.o_sel[SEL_W-1:CH_BITS];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lfsr_d[c]  = lfsr_q[c];
      wdata_d[c] = wdata_q[c];
      if (mode == MODE_LOAD) begin
        lfsr_d[c] = nz(nz(bus.seed_in) + 32'(c));
      end else if (advance) begin
        lfsr_d[c]  = lfsr_next(lfsr_q[c]);
        wdata_d[c] = shift_in(wdata_q[c], lfsr_next(lfsr_q[c]));
      end
    end
  end

  // Channels beyond NUM_CH match no loop iteration and read back as zero.
  always_comb begin
    o_data_d = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ch_sel) == c) o_data_d = bus.rdata_flat[c*W + int'(byte_sel)*8 +: 8];
    end
  end

  always_comb begin
    fold = 32'h0;
    for (int i = 0; i < NWORDS; i++) fold = fold ^ bus.rdata_flat[i*32 +: 32];
  end

  // Clear has priority over capture; the count saturates but the signature keeps folding.
  always_comb begin
    sig_d = sig_q;
    cap_d = cap_q;
    if (bus.sig_clear) begin
      sig_d = 32'h0;
      cap_d = 16'h0;
    end else if (bus.capture_en) begin
      sig_d = lfsr_next(sig_q) ^ fold;
      cap_d = (cap_q == 16'hFFFF) ? cap_q : cap_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr_q[c]  <= nz(SEED + 32'(c));
        wdata_q[c] <= '0;
      end
      o_data_q <= 8'h00;
      sig_q    <= 32'h0;
      cap_q    <= 16'h0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr_q[c]  <= lfsr_d[c];
        wdata_q[c] <= wdata_d[c];
      end
      o_data_q <= o_data_d;
      sig_q    <= sig_d;
      cap_q    <= cap_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdata
    assign bus.wdata_flat[g*W +: W] = wdata_q[g];
  end

  assign bus.o_data    = o_data_q;
  assign bus.o_sig     = sig_q;
  assign bus.cap_count = cap_q;
endmodule

// File: tb/tb_rand_io_harness.sv
// Directed self-checking bench for rand_io_harness: a 2-channel 256-bit
// instance plus a 3-channel 32-bit instance for the out-of-range channel case.
module tb_rand_io_harness;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  rand_io_harness_if #(.NUM_CH(2), .LANES(32), .DWIDTH(8)) u_if ();
  rand_io_harness_if #(.NUM_CH(3), .LANES(4),  .DWIDTH(8)) u_if3 ();

  rand_io_harness #(.NUM_CH(2), .LANES(32), .DWIDTH(8), .SEED(32'h1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  rand_io_harness #(.NUM_CH(3), .LANES(4), .DWIDTH(8), .SEED(32'h1)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if3)
  );

  logic [31:0] m [9];
  logic [31:0] n [9];

  function automatic logic [31:0] lfsr_model(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] wword(input int ch, input int j);
    return u_if.wdata_flat[ch*256 + j*32 +: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    m[0] = 32'h1;
    n[0] = 32'h2;
    for (int k = 1; k < 9; k++) begin
      m[k] = lfsr_model(m[k-1]);
      n[k] = lfsr_model(n[k-1]);
    end

    reset = 1'b1;
    u_if.gen_mode = 2'b00;  u_if.step = 1'b0;  u_if.seed_in = 32'h0;
    u_if.rdata_flat = '0;   u_if.o_sel = '0;   u_if.capture_en = 1'b0;
    u_if.sig_clear = 1'b0;
    u_if3.gen_mode = 2'b00; u_if3.step = 1'b0; u_if3.seed_in = 32'h0;
    u_if3.rdata_flat = '1;  u_if3.o_sel = '0;  u_if3.capture_en = 1'b0;
    u_if3.sig_clear = 1'b0;
    tick();
    reset = 1'b0;

    check("rst_wdata",  wword(0, 0), 32'h0);
    check("rst_sig",    u_if.o_sig, 32'h0);
    check("rst_cnt",    32'(u_if.cap_count), 32'h0);
    check("rst_odata",  32'(u_if.o_data), 32'h0);

    // Free-run: first advance, then the full 8-word refresh.
    u_if.gen_mode = 2'b01;
    tick();
    check("free1_ch0_w0", wword(0, 0), 32'h00000003);
    check("free1_ch1_w0", wword(1, 0), 32'h00000005);
    check("free1_ch0_w1", wword(0, 1), 32'h0);
    check("free1_ch1_w7", wword(1, 7), 32'h0);
    tick(7);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("free8_ch0_w%0d", j), wword(0, j), m[8-j]);
      check($sformatf("free8_ch1_w%0d", j), wword(1, j), n[8-j]);
      check($sformatf("free8_nz_w%0d", j), 32'(wword(0, j) != 0 && wword(1, j) != 0), 32'h1);
    end

    // Hold freezes the words.
    do_reset();
    u_if.gen_mode = 2'b01;
    tick(4);
    u_if.gen_mode = 2'b00;
    tick(10);
    check("hold_w0", wword(0, 0), m[4]);
    check("hold_w3", wword(0, 3), 32'h00000003);
    check("hold_w4", wword(0, 4), 32'h0);

    // Step mode: three pulses over ten cycles give three advances.
    do_reset();
    u_if.gen_mode = 2'b10;
    for (int i = 0; i < 10; i++) begin
      u_if.step = (i == 1 || i == 4 || i == 7);
      tick();
    end
    u_if.step = 1'b0;
    check("step_w0", wword(0, 0), m[3]);
    check("step_w2", wword(0, 2), m[1]);
    check("step_w3", wword(0, 3), 32'h0);
    check("step_ch1_w0", wword(1, 0), n[3]);
    u_if.gen_mode = 2'b00;
    u_if.step = 1'b1;
    tick();
    u_if.step = 1'b0;
    check("step_in_hold", wword(0, 0), m[3]);

    // Load with a zero seed, then with a seed whose +1 wraps to zero.
    u_if.gen_mode = 2'b11;
    u_if.seed_in = 32'h0;
    tick();
    check("load_keeps_w", wword(0, 0), m[3]);
    u_if.gen_mode = 2'b01;
    tick();
    check("load0_ch0", wword(0, 0), 32'h00000003);
    check("load0_ch1", wword(1, 0), 32'h00000005);
    check("load0_ch0_w1", wword(0, 1), m[3]);
    u_if.gen_mode = 2'b11;
    u_if.seed_in = 32'hFFFFFFFF;
    tick();
    u_if.gen_mode = 2'b01;
    tick();
    check("loadF_ch0", wword(0, 0), 32'hFFFFFFFE);
    check("loadF_ch1", wword(1, 0), 32'h00000003);

    // Observation port.
    do_reset();
    u_if.rdata_flat = '0;
    u_if.rdata_flat[1*256 + 5*8 +: 8] = 8'h3C;
    u_if.o_sel = {5'd5, 1'b1};
    u_if3.o_sel = {2'd2, 2'd3};
    #1;
    check("obs_before_edge", 32'(u_if.o_data), 32'h0);
    tick();
    check("obs_ch1_b5", 32'(u_if.o_data), 32'h3C);
    check("obs3_ch3", 32'(u_if3.o_data), 32'h0);
    u_if.o_sel = {5'd5, 1'b0};
    u_if3.o_sel = {2'd3, 2'd2};
    tick();
    check("obs_ch0_b5", 32'(u_if.o_data), 32'h0);
    check("obs3_ch2_b3", 32'(u_if3.o_data), 32'hFF);
    u_if.o_sel = {5'd4, 1'b1};
    tick();
    check("obs_ch1_b4", 32'(u_if.o_data), 32'h0);

    // MISR folding, clear priority and cross-channel XOR.
    do_reset();
    u_if.rdata_flat = '0;
    u_if.rdata_flat[31:0] = 32'hA5;
    u_if.capture_en = 1'b1;
    tick();
    check("misr1", u_if.o_sig, 32'h000000A5);
    tick();
    check("misr2", u_if.o_sig, 32'h000001EE);
    check("misr_cnt2", 32'(u_if.cap_count), 32'h2);
    u_if.sig_clear = 1'b1;
    tick();
    check("clr_sig", u_if.o_sig, 32'h0);
    check("clr_cnt", 32'(u_if.cap_count), 32'h0);
    u_if.sig_clear = 1'b0;
    u_if.rdata_flat = '0;
    u_if.rdata_flat[1*256 + 7*32 +: 32] = 32'h12345678;
    u_if.rdata_flat[3*32 +: 32] = 32'h0000FFFF;
    tick();
    check("misr_fold", u_if.o_sig, 32'h1234A987);
    u_if.capture_en = 1'b0;
    tick();
    check("misr_idle_sig", u_if.o_sig, 32'h1234A987);
    check("misr_idle_cnt", 32'(u_if.cap_count), 32'h1);

    // Counter saturation.
    u_if.sig_clear = 1'b1;
    tick();
    u_if.sig_clear = 1'b0;
    u_if.capture_en = 1'b1;
    tick(65534);
    check("cnt_fffe", 32'(u_if.cap_count), 32'h0000FFFE);
    tick();
    check("cnt_ffff", 32'(u_if.cap_count), 32'h0000FFFF);
    tick(5);
    check("cnt_sat", 32'(u_if.cap_count), 32'h0000FFFF);

    // Reset in the middle of free-run with capture active.
    u_if.seed_in = 32'hDEADBEEF;
    u_if.rdata_flat = '0;
    u_if.rdata_flat[1*256 + 5*8 +: 8] = 8'h3C;
    u_if.o_sel = {5'd5, 1'b1};
    u_if.gen_mode = 2'b01;
    tick(5);
    reset = 1'b1;
    tick();
    check("mrst_ch0", wword(0, 0), 32'h0);
    check("mrst_ch1", wword(1, 7), 32'h0);
    check("mrst_sig", u_if.o_sig, 32'h0);
    check("mrst_cnt", 32'(u_if.cap_count), 32'h0);
    check("mrst_odata", 32'(u_if.o_data), 32'h0);
    reset = 1'b0;
    tick();
    check("mrst_ch0_seed", wword(0, 0), 32'h00000003);
    check("mrst_ch1_seed", wword(1, 0), 32'h00000005);
    check("mrst_sig1", u_if.o_sig, 32'h00003C00);
    check("mrst_cnt1", 32'(u_if.cap_count), 32'h1);
    check("mrst_odata1", 32'(u_if.o_data), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rand_io_harness.md
Name: rand_io_harness

Overview:
- Parametrised stimulus/observation harness placed around a wide multi-port memory-style datapath, such as a matrix-unit top with several BRAM ports.
- Per channel, generates a W-bit pseudo-random write-data word from a seeded 32-bit LFSR, with selectable advance modes.
- Compresses all channels' read data into a 32-bit MISR signature and a capture counter.
- Exposes any read-data byte of any channel through a registered 8-bit observation port.

Parameters:
- NUM_CH, 2: number of data channels (1..16).
- LANES, 32: lanes per channel word.
- DWIDTH, 8: bits per lane. W = LANES*DWIDTH; W must be a multiple of 32.
- SEED, 32'h1: base seed. Channel c seed = SEED + c (mod 2^32); a computed seed of 0 is replaced by 32'h1.
- Derived: CH_BITS = max(1, clog2(NUM_CH)); BYTE_BITS = clog2(W/8); SEL_W = CH_BITS + BYTE_BITS.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- gen_mode  in  2  00 hold, 01 free-run, 10 step, 11 load.
- step  in  1  one advance per high cycle, in step mode only.
- seed_in  in  32  value loaded into every channel LFSR in load mode.
- wdata_flat  out  NUM_CH*W  channel c occupies bits [c*W +: W].
- rdata_flat  in  NUM_CH*W  read data, same packing.
- o_sel  in  SEL_W  [CH_BITS-1:0] selects channel; upper bits select byte.
- o_data  out  8  registered selected read-data byte.
- capture_en  in  1  fold rdata into the MISR this cycle.
- sig_clear  in  1  zero the signature and the counter.
- o_sig  out  32  MISR signature.
- cap_count  out  16  number of capture cycles, saturating.

Behaviour:
- Reset (synchronous): lfsr[c] = seed_c; wdata_flat = 0; o_data = 0; o_sig = 0; cap_count = 0. Reset overrides every other input in the same cycle.
- LFSR advance: lfsr' = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
- Channel word shift on each advance: w' = {w[W-33:0], lfsr'}. The newest 32-bit word enters at the low end. A full word refreshes after W/32 advances.
- Modes, evaluated per cycle:
  - hold: no change.
  - free-run: advance every cycle.
  - step: advance only in cycles with step=1; step is ignored in other modes.
  - load: every lfsr[c] <= (seed_in==0 ? 32'h1 : seed_in) + c, with 0 replaced by 1; wdata unchanged; no advance.
- All channels advance in lockstep. Changing mode takes effect on the next edge; there is no residual step.
- o_data <= byte o_sel[SEL_W-1:CH_BITS] of channel o_sel[CH_BITS-1:0] of rdata_flat. Byte k = bits [8k+7:8k].
  - Latency 1 cycle.
  - A channel index >= NUM_CH gives 8'h00.
- MISR: fold = XOR of all NUM_CH*W/32 32-bit words of rdata_flat.
  - When capture_en: sig' = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold.
  - cap_count += 1, saturating at 16'hFFFF; the signature keeps updating after saturation.
- sig_clear: sig = 0 and cap_count = 0. If asserted together with capture_en, clear wins; that cycle's data is not folded or counted.
- Mid-operation reset: the LFSRs restart from the seed_c values, not from seed_in.
- The LFSR can never reach 0 because seeds are zero-guarded.

Test Plan:
- Free-run after reset (NUM_CH=2, SEED=1): one cycle of mode 01 -> ch0 low word 32'h00000003, ch1 low word 32'h00000005, upper words 0. After 8 cycles (W=256) no word is 0 and each word equals the lfsr sequence in order.
- Mode 01 for 4 cycles, then hold 10 cycles -> wdata_flat stays frozen. Step mode with 3 single-cycle step pulses over 10 cycles -> exactly 3 advances, matching free-run after 3 cycles. A step pulse in hold mode -> no change.
- Load with seed_in=0 (NUM_CH=2), then one free-run cycle -> ch0 lfsr 1 gives low word 32'h00000003; ch1 lfsr 2 gives 32'h00000005.
- Set rdata ch1 byte 5 = 8'h3C and o_sel = {byte 5, ch 1} -> o_data = 8'h3C exactly one cycle later. With NUM_CH=3 and channel index 3 -> o_data = 8'h00.
- rdata zero except ch0 word0 = 32'hA5; capture 2 cycles -> o_sig 32'hA5, then 32'h1EE; cap_count = 2. sig_clear together with capture_en -> o_sig 0, cap_count 0.
- Hold capture_en for 65 540 cycles -> cap_count stays at 16'hFFFF. Assert reset mid-free-run -> next cycle all outputs 0 and the LFSRs are back at seed_c.
